// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed N-digit common-anode 7-segment driver with hex/LZ/blank/dp.
// Latency: load visible on outputs one cycle after capture; outputs registered one cycle after (idx, presc).
// No backpressure: load is level-sampled every cycle and never disturbs the scan timing.
module seg7_scan #(
  parameter int NDIG        = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEADTIME    = 1000,
  parameter int HEX_EN      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*NDIG-1:0]   data_in,
  input  logic [NDIG-1:0]     dp_in,
  input  logic [NDIG-1:0]     blank_in,
  input  logic                lz_en,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [NDIG-1:0]     an
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NDIG - 1);
  localparam logic [PW-1:0] DT_V      = PW'(DEADTIME);

  logic [4*NDIG-1:0] data_q;
  logic [NDIG-1:0]   dp_q, blank_q, mask_q, mask_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_o_q, dp_o_d;
  logic [NDIG-1:0]   an_q, an_d;

  logic [3:0] cur_nib;
  logic       cur_dp, cur_blank, above_zero, lit;
  logic [6:0] dec;

  // Zero-mask: digit k is suppressed when it and every digit to its left are zero.
  always_comb begin
    mask_d     = '0;
    above_zero = 1'b1;
    for (int k = NDIG - 1; k >= 1; k--) begin
      above_zero = above_zero & (data_in[4*k +: 4] == 4'h0);
      mask_d[k]  = lz_en & above_zero;
    end
  end

  // Shadow capture; load held high simply recaptures every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      mask_q  <= '0;
    end else if (load) begin
      data_q  <= data_in;
      dp_q    <= dp_in;
      blank_q <= blank_in;
      mask_q  <= mask_d;
    end
  end

  // Scan timing: prescaler defines the slot, idx steps at the last cycle of each slot.
  always_comb begin
    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_MAX) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
  end

  // Scan counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // Select the current digit's shadow fields without a variable-width index.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx_q == IW'(k)) begin
        cur_nib   = data_q[4*k +: 4];
        cur_dp    = dp_q[k];
        cur_blank = blank_q[k] | mask_q[k];
      end
    end
  end

  // Active-low segment decode {a,b,c,d,e,f,g}; hex codes blank when hex is disabled.
  always_comb begin
    dec = 7'h7F;
    case (cur_nib)
      4'h0: dec = 7'b0000001;
      4'h1: dec = 7'b1001111;
      4'h2: dec = 7'b0010010;
      4'h3: dec = 7'b0000110;
      4'h4: dec = 7'b1001100;
      4'h5: dec = 7'b0100100;
      4'h6: dec = 7'b0100000;
      4'h7: dec = 7'b0001111;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0000100;
      4'hA: dec = (HEX_EN != 0) ? 7'b0001000 : 7'h7F;
      4'hB: dec = (HEX_EN != 0) ? 7'b1100000 : 7'h7F;
      4'hC: dec = (HEX_EN != 0) ? 7'b0110001 : 7'h7F;
      4'hD: dec = (HEX_EN != 0) ? 7'b1000010 : 7'h7F;
      4'hE: dec = (HEX_EN != 0) ? 7'b0110000 : 7'h7F;
      4'hF: dec = (HEX_EN != 0) ? 7'b0111000 : 7'h7F;
      default: dec = 7'h7F;
    endcase
  end

  // Next output values: segments hold for the whole slot, anode only after deadtime.
  always_comb begin
    lit    = (presc_q >= DT_V);
    seg_d  = cur_blank ? 7'h7F : dec;
    dp_o_d = cur_blank ? 1'b1 : ~cur_dp;
    an_d   = '1;
    for (int k = 0; k < NDIG; k++) begin
      an_d[k] = ~(lit & (idx_q == IW'(k)));
    end
  end

  // Registered pin drivers, all dark in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q  <= 7'h7F;
      dp_o_q <= 1'b1;
      an_q   <= '1;
    end else begin
      seg_q  <= seg_d;
      dp_o_q <= dp_o_d;
      an_q   <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_o_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized and directed bench for seg7_scan against a time-based reference model.
// Model derives slot/position from cycles since reset and decodes from a table.
// Two DUT copies share stimulus: hex decode enabled and disabled.
module tb_seg7_scan;
  localparam int NDIG = 4;
  localparam int RD   = 8;
  localparam int DT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [6:0]  seg, seg_nh;
  logic        dp, dp_nh;
  logic [3:0]  an, an_nh;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles since reset plus captured display contents.
  int          t = 0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp = '0, m_blank = '0, m_mask = '0;
  logic [6:0]  exp_seg, exp_seg_nh;
  logic        exp_dp;
  logic [3:0]  exp_an;

  seg7_scan #(.NDIG(NDIG), .REFRESH_DIV(RD), .DEADTIME(DT), .HEX_EN(1)) u_dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en), .seg(seg), .dp(dp), .an(an)
  );

  seg7_scan #(.NDIG(NDIG), .REFRESH_DIV(RD), .DEADTIME(DT), .HEX_EN(0)) u_dut_nh (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en), .seg(seg_nh), .dp(dp_nh), .an(an_nh)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_dec(input logic [3:0] n, input bit hex);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'b0000001;  4'h1: r = 7'b1001111;
      4'h2: r = 7'b0010010;  4'h3: r = 7'b0000110;
      4'h4: r = 7'b1001100;  4'h5: r = 7'b0100100;
      4'h6: r = 7'b0100000;  4'h7: r = 7'b0001111;
      4'h8: r = 7'b0000000;  4'h9: r = 7'b0000100;
      4'hA: r = 7'b0001000;  4'hB: r = 7'b1100000;
      4'hC: r = 7'b0110001;  4'hD: r = 7'b1000010;
      4'hE: r = 7'b0110000;  default: r = 7'b0111000;
    endcase
    if (!hex && n > 4'd9) r = 7'h7F;
    return r;
  endfunction

  // Predict the outputs produced by the coming edge, update the model, advance one cycle.
  task automatic step();
    int d, pos;
    logic [3:0] nib, onehot;
    bit blk;
    if (rst) begin
      exp_seg = 7'h7F; exp_seg_nh = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF;
    end else begin
      d   = (t / RD) % NDIG;
      pos = t % RD;
      nib = m_data[4*d +: 4];
      blk = m_blank[d] | m_mask[d];
      exp_seg    = blk ? 7'h7F : ref_dec(nib, 1'b1);
      exp_seg_nh = blk ? 7'h7F : ref_dec(nib, 1'b0);
      exp_dp     = blk ? 1'b1 : ~m_dp[d];
      onehot     = 4'b0001 << d;
      exp_an     = (pos >= DT) ? ~onehot : 4'hF;
    end
    if (rst) begin
      t = 0; m_data = '0; m_dp = '0; m_blank = '0; m_mask = '0;
    end else begin
      t++;
      if (load) begin
        m_data = data_in; m_dp = dp_in; m_blank = blank_in; m_mask = '0;
        if (lz_en)
          for (int k = 1; k < NDIG; k++)
            if ((data_in >> (4 * k)) == 16'h0) m_mask[k] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({seg, dp, an} !== {7'h7F, 1'b1, 4'hF}) begin
        errors++;
        $display("FAIL reset cyc%0d: got seg=%b dp=%b an=%b want 1111111 1 1111", i, seg, dp, an);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 2 * RD; i++) begin
      step();
      checks++;
      if (an !== exp_an) begin
        errors++;
        $display("FAIL reset_release cyc%0d: got an=%b want %b", i, an, exp_an);
      end
    end
  endtask

  task automatic test_scan();
    data_in = 16'h1234; dp_in = 4'h0; blank_in = 4'h0; lz_en = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < NDIG * RD + 4; i++) begin
      step();
      checks++;
      if ({seg, dp, an} !== {exp_seg, exp_dp, exp_an}) begin
        errors++;
        $display("FAIL scan cyc%0d: got %b %b %b want %b %b %b", i, seg, dp, an, exp_seg, exp_dp, exp_an);
      end
    end
  endtask

  task automatic test_hex();
    data_in = 16'hABCF; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < NDIG * RD; i++) begin
      step();
      checks++;
      if ({seg, seg_nh, an} !== {exp_seg, exp_seg_nh, exp_an}) begin
        errors++;
        $display("FAIL hex cyc%0d: got seg=%b nohex=%b an=%b want %b %b %b",
                 i, seg, seg_nh, an, exp_seg, exp_seg_nh, exp_an);
      end
    end
  endtask

  task automatic test_lz();
    logic [15:0] pats [2];
    pats[0] = 16'h0050; pats[1] = 16'h0000;
    lz_en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      data_in = pats[p]; load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < NDIG * RD; i++) begin
        step();
        checks++;
        if ({seg, dp, an} !== {exp_seg, exp_dp, exp_an}) begin
          errors++;
          $display("FAIL lz %h cyc%0d: got %b %b %b want %b %b %b",
                   pats[p], i, seg, dp, an, exp_seg, exp_dp, exp_an);
        end
      end
    end
    lz_en = 1'b0;
  endtask

  task automatic test_blank_dp();
    data_in = 16'h8765; blank_in = 4'b0010; dp_in = 4'b0011; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < NDIG * RD; i++) begin
      step();
      checks++;
      if ({seg, dp, an} !== {exp_seg, exp_dp, exp_an}) begin
        errors++;
        $display("FAIL blank_dp cyc%0d: got %b %b %b want %b %b %b", i, seg, dp, an, exp_seg, exp_dp, exp_an);
      end
    end
    blank_in = 4'h0; dp_in = 4'h0;
  endtask

  task automatic test_mid_op();
    logic [3:0] prev_an;
    data_in = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < RD && (t % RD) != 4; i++) step();
    data_in = 16'h9999; load = 1'b1;
    step();
    load = 1'b0;
    prev_an = an;
    step();
    checks++;
    if (an !== prev_an || seg !== 7'b0000100 || seg !== exp_seg) begin
      errors++;
      $display("FAIL mid_load: got seg=%b an=%b want seg=0000100 an=%b", seg, an, prev_an);
    end
    for (int i = 0; i < NDIG * RD && ((t / RD) % NDIG) != 2; i++) step();
    step(); step(); step();
    checks++;
    if (((t / RD) % NDIG) != 2 || an !== 4'b1011) begin
      errors++;
      $display("FAIL mid_reach_idx2: got an=%b want 1011", an);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({seg, dp, an} !== {7'h7F, 1'b1, 4'hF}) begin
      errors++;
      $display("FAIL mid_reset: got %b %b %b want 1111111 1 1111", seg, dp, an);
    end
    rst = 1'b0;
    for (int i = 0; i < RD + 2; i++) begin
      step();
      checks++;
      if ({seg, dp, an} !== {exp_seg, exp_dp, exp_an}) begin
        errors++;
        $display("FAIL mid_restart cyc%0d: got %b %b %b want %b %b %b", i, seg, dp, an, exp_seg, exp_dp, exp_an);
      end
      if (i == DT) begin
        checks++;
        if (an !== 4'hE) begin
          errors++;
          $display("FAIL mid_restart_an: got an=%b want 1110", an);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    load = 1'b1;
    for (int i = 0; i < 3 * NDIG * RD; i++) begin
      data_in  = 16'($urandom);
      dp_in    = 4'($urandom);
      blank_in = 4'($urandom) & 4'($urandom);
      lz_en    = 1'($urandom);
      step();
      checks++;
      if ({seg, seg_nh, dp, an} !== {exp_seg, exp_seg_nh, exp_dp, exp_an}) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: got %b %b %b %b want %b %b %b %b",
                 i, seg, seg_nh, dp, an, exp_seg, exp_seg_nh, exp_dp, exp_an);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load     = ($urandom_range(0, 7) == 0);
      data_in  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      dp_in    = 4'($urandom);
      blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      lz_en    = 1'($urandom);
      step();
      checks++;
      if ({seg, seg_nh, dp, an} !== {exp_seg, exp_seg_nh, exp_dp, exp_an}) begin
        errors++;
        $display("FAIL random cyc%0d: got %b %b %b %b want %b %b %b %b",
                 i, seg, seg_nh, dp, an, exp_seg, exp_seg_nh, exp_dp, exp_an);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hex();
    test_lz();
    test_blank_dp();
    test_mid_op();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
